// File: rtl/memsys_if.sv
// memsys_if: fetch and load/store handshake bundle for memsys; d_byte exists only with MEMSYS_BYTE_EN
interface memsys_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32
);
    logic              i_req;
    logic [ADDR_W-1:0] i_addr;
    logic [DATA_W-1:0] i_rdata;
    logic              i_valid;
    logic              d_req;
    logic              d_we;
    logic [ADDR_W-1:0] d_addr;
    logic [DATA_W-1:0] d_wdata;
    logic [DATA_W-1:0] d_rdata;
    logic              d_valid;
`ifdef MEMSYS_BYTE_EN
    logic              d_byte;
`endif

    modport master (
`ifdef MEMSYS_BYTE_EN
        output d_byte,
`endif
        output i_req, i_addr, d_req, d_we, d_addr, d_wdata,
        input  i_rdata, i_valid, d_rdata, d_valid
    );

    modport slave (
`ifdef MEMSYS_BYTE_EN
        input  d_byte,
`endif
        input  i_req, i_addr, d_req, d_we, d_addr, d_wdata,
        output i_rdata, i_valid, d_rdata, d_valid
    );
endinterface

// File: rtl/memsys.sv
// memsys: shared single-port RAM with round-robin fetch/data arbitration; MEMSYS_BYTE_EN adds byte loads/stores
module memsys #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32,
    parameter int DEPTH  = 64,
    parameter int WAIT   = 1
) (
    input logic clk,
    input logic reset,
    memsys_if.slave bus
);
    localparam int IW = $clog2(DEPTH);

    typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

    state_t            state;
    logic [3:0]        cnt;
    logic              sel_d;
    logic              prefer_d;
    logic              we;
    logic [IW-1:0]     idx;
    logic [DATA_W-1:0] wdata;
    logic [DATA_W-1:0] rd_word;
    logic [DATA_W-1:0] wr_word;
    logic [DATA_W-1:0] rd_data;
    logic              win_d;
    logic              access;
    logic              unused_bits;
    logic [DATA_W-1:0] mem [DEPTH];

    assign win_d   = bus.d_req && (!bus.i_req || prefer_d);
    assign access  = state == BUSY && cnt == 4'd0;
    assign rd_word = mem[idx];
    assign unused_bits = ^{bus.i_addr[ADDR_W-1:IW+2], bus.i_addr[1:0], bus.d_addr[ADDR_W-1:IW+2], bus.d_addr[1:0]};

`ifdef MEMSYS_BYTE_EN
    logic              byte_acc;
    logic [1:0]        lane;
    logic [DATA_W-1:0] lane_mask;

    assign lane_mask = DATA_W'(8'hFF) << {lane, 3'b000};
    assign wr_word   = byte_acc ? (rd_word & ~lane_mask) | (DATA_W'(wdata[7:0]) << {lane, 3'b000}) : wdata;
    assign rd_data   = byte_acc ? DATA_W'(8'(rd_word >> {lane, 3'b000})) : rd_word;
`else
    assign wr_word = wdata;
    assign rd_data = rd_word;
`endif

    always_ff @(posedge clk or negedge reset)
        if (!reset) begin
            state       <= IDLE;
            cnt         <= 4'd0;
            sel_d       <= 1'b0;
            prefer_d    <= 1'b1;
            we          <= 1'b0;
            idx         <= '0;
            wdata       <= '0;
            bus.i_valid <= 1'b0;
            bus.d_valid <= 1'b0;
            bus.i_rdata <= '0;
            bus.d_rdata <= '0;
`ifdef MEMSYS_BYTE_EN
            byte_acc    <= 1'b0;
            lane        <= 2'd0;
`endif
        end else begin
            bus.i_valid <= 1'b0;
            bus.d_valid <= 1'b0;
            if (state == IDLE && (bus.i_req || bus.d_req)) begin
                sel_d    <= win_d;
                prefer_d <= !win_d;
                we       <= win_d && bus.d_we;
                idx      <= win_d ? bus.d_addr[IW+1:2] : bus.i_addr[IW+1:2];
                wdata    <= bus.d_wdata;
`ifdef MEMSYS_BYTE_EN
                byte_acc <= win_d && bus.d_byte;
                lane     <= bus.d_addr[1:0];
`endif
                cnt      <= 4'(WAIT);
                state    <= BUSY;
            end else if (state == BUSY) begin
                if (cnt != 4'd0)
                    cnt <= cnt - 4'd1;
                else begin
                    state       <= RESP;
                    bus.i_valid <= !sel_d;
                    bus.d_valid <= sel_d;
                    if (sel_d && !we)
                        bus.d_rdata <= rd_data;
                    if (!sel_d)
                        bus.i_rdata <= rd_word;
                end
            end else if (state == RESP)
                state <= IDLE;
        end

    // an access aborted by reset never reaches BUSY with cnt==0, so it cannot write
    always_ff @(posedge clk)
        if (access && we)
            mem[idx] <= wr_word;
endmodule

// File: tb/tb_memsys.sv
module tb_memsys;
    localparam int DW = 32, AW = 32, DEPTH = 64, W = 1;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    memsys_if #(.DATA_W(DW), .ADDR_W(AW)) bus();
    memsys #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(DEPTH), .WAIT(W)) dut (.clk(clk), .reset(reset), .bus(bus));

    int n_checks = 0, n_fail = 0;
    logic [31:0] model [DEPTH];
    logic [31:0] last_d = '0, last_i = '0;
    logic [31:0] dq[$], iq[$];
    logic pv_d = 1'b0, pv_i = 1'b0;
    bit sweep_go = 1'b0;
    int sweep_done = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    always @(negedge clk)
        if (reset) begin
            if (bus.d_valid) begin
                check("d_pulse_width", pv_d, 0);
                if (dq.size() == 0) check("d_unexpected_valid", bus.d_valid, 0);
                else check("d_rdata", bus.d_rdata, dq.pop_front());
            end
            if (bus.i_valid) begin
                check("i_pulse_width", pv_i, 0);
                if (iq.size() == 0) check("i_unexpected_valid", bus.i_valid, 0);
                else check("i_rdata", bus.i_rdata, iq.pop_front());
            end
            pv_d = bus.d_valid;
            pv_i = bus.i_valid;
        end

    task automatic d_op(input logic we, input logic [31:0] a, input logic [31:0] w, input logic bsel,
                        input int exp_lat, input string tag);
        int lat = 0;
        int k = (a >> 2) % DEPTH;
        logic [31:0] word;
        @(negedge clk);
        if (we) begin
            word = model[k];
            if (bsel) word[a[1:0]*8 +: 8] = w[7:0];
            else word = w;
            model[k] = word;
        end else
            last_d = bsel ? (model[k] >> (a[1:0] * 8)) & 32'hFF : model[k];
        dq.push_back(last_d);
        bus.d_req = 1'b1;
        bus.d_we = we;
        bus.d_addr = a;
        bus.d_wdata = w;
`ifdef MEMSYS_BYTE_EN
        bus.d_byte = bsel;
`endif
        while (lat < 100) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
            if (bus.d_valid) break;
        end
        bus.d_req = 1'b0;
        check(tag, lat, exp_lat);
    endtask

    task automatic i_op(input logic [31:0] a, input int exp_lat, input string tag);
        int lat = 0;
        @(negedge clk);
        last_i = model[(a >> 2) % DEPTH];
        iq.push_back(last_i);
        bus.i_req = 1'b1;
        bus.i_addr = a;
        while (lat < 100) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
            if (bus.i_valid) break;
        end
        bus.i_req = 1'b0;
        check(tag, lat, exp_lat);
    endtask

    initial begin
        bus.i_req = 1'b0;
        bus.i_addr = '0;
        bus.d_req = 1'b0;
        bus.d_we = 1'b0;
        bus.d_addr = '0;
        bus.d_wdata = '0;
`ifdef MEMSYS_BYTE_EN
        bus.d_byte = 1'b0;
`endif
        repeat (2) @(negedge clk);
        check("rst_d_valid", bus.d_valid, 0);
        check("rst_i_valid", bus.i_valid, 0);
        check("rst_d_rdata", bus.d_rdata, 0);
        check("rst_i_rdata", bus.i_rdata, 0);
        reset = 1'b1;

        d_op(1'b1, 32'h20, 32'h12345678, 1'b0, W + 2, "st_lat");
        d_op(1'b0, 32'h20, 32'h0, 1'b0, W + 2, "ld_lat");
        check("ld_data", bus.d_rdata, 32'h12345678);

        d_op(1'b1, 32'h104, 32'hA5A5A5A5, 1'b0, W + 2, "alias_st_lat");
        i_op(32'h004, W + 2, "alias_fetch_lat");
        check("alias_data", bus.i_rdata, 32'hA5A5A5A5);
        check("store_holds_d_rdata", bus.d_rdata, 32'h12345678);

        d_op(1'b1, 32'h0, 32'hCAFEF00D, 1'b0, W + 2, "pre_st0_lat");
        d_op(1'b1, 32'h10, 32'h11111111, 1'b0, W + 2, "pre_st10_lat");
        d_op(1'b0, 32'h10, 32'h0, 1'b0, W + 2, "pre_ld10_lat");

        // start a store, then pull reset while it sits in BUSY
        @(negedge clk);
        bus.d_req = 1'b1;
        bus.d_we = 1'b1;
        bus.d_addr = 32'h10;
        bus.d_wdata = 32'hDEADBEEF;
        @(posedge clk);
        #1 reset = 1'b0;
        #1;
        check("abort_d_valid", bus.d_valid, 0);
        check("abort_i_valid", bus.i_valid, 0);
        check("abort_d_rdata", bus.d_rdata, 0);
        check("abort_i_rdata", bus.i_rdata, 0);
        @(negedge clk);
        bus.d_req = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        last_d = '0;
        last_i = '0;

        fork
            begin
                d_op(1'b0, 32'h4, 32'h0, 1'b0, W + 2, "tie1_d_lat");
                d_op(1'b0, 32'h10, 32'h0, 1'b0, 2 * W + 5, "tie2_d_lat");
            end
            i_op(32'h0, 2 * W + 5, "tie1_i_lat");
        join
        check("abort_no_write", bus.d_rdata, 32'h11111111);
        check("tie_fetch_data", bus.i_rdata, 32'hCAFEF00D);

`ifdef MEMSYS_BYTE_EN
        d_op(1'b1, 32'h30, 32'h11223344, 1'b0, W + 2, "bw_st_lat");
        d_op(1'b1, 32'h31, 32'h000000FF, 1'b1, W + 2, "bb_st_lat");
        d_op(1'b0, 32'h30, 32'h0, 1'b0, W + 2, "bw_ld_lat");
        check("byte_merge", bus.d_rdata, 32'h1122FF44);
        d_op(1'b0, 32'h33, 32'h0, 1'b1, W + 2, "bb_ld_lat");
        check("byte_load", bus.d_rdata, 32'h00000011);
`endif

        sweep_go = 1'b1;
        for (int c = 0; c < 2000 && sweep_done < 2; c++) @(negedge clk);
        check("sweep_finished", sweep_done, 2);
        check("sb_empty", dq.size() + iq.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    for (genvar g = 0; g < 2; g++) begin : sw
        localparam int SW = g ? 15 : 0;
        memsys_if #(.DATA_W(DW), .ADDR_W(AW)) sb();
        memsys #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(DEPTH), .WAIT(SW)) sdut (.clk(clk), .reset(reset), .bus(sb));

        initial begin
            int nv = 0, highs = 0, lat = 0;
            int v [2] = '{0, 0};
            sb.i_req = 1'b0;
            sb.i_addr = '0;
            sb.d_req = 1'b0;
            sb.d_we = 1'b0;
            sb.d_addr = '0;
            sb.d_wdata = '0;
`ifdef MEMSYS_BYTE_EN
            sb.d_byte = 1'b0;
`endif
            wait (sweep_go);
            @(negedge clk);
            // req held across two stores: back-to-back pulses must be WAIT+3 apart
            sb.d_req = 1'b1;
            sb.d_we = 1'b1;
            sb.d_addr = 32'h8;
            sb.d_wdata = 32'h600D0000 + g;
            for (int c = 1; c <= 2 * SW + 8; c++) begin
                @(posedge clk);
                @(negedge clk);
                if (sb.d_valid) begin
                    highs++;
                    if (nv < 2) v[nv] = c;
                    nv++;
                    if (nv == 2) sb.d_req = 1'b0;
                end
            end
            check($sformatf("sweep%0d_lat", SW), v[0], SW + 2);
            check($sformatf("sweep%0d_period", SW), v[1] - v[0], SW + 3);
            check($sformatf("sweep%0d_pulses", SW), highs, 2);
            @(negedge clk);
            sb.d_we = 1'b0;
            sb.d_req = 1'b1;
            while (lat < 100) begin
                @(posedge clk);
                lat++;
                @(negedge clk);
                if (sb.d_valid) break;
            end
            sb.d_req = 1'b0;
            check($sformatf("sweep%0d_ld_lat", SW), lat, SW + 2);
            check($sformatf("sweep%0d_ld_data", SW), sb.d_rdata, 32'h600D0000 + g);
            sweep_done++;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, got no end expected end");
        $fatal(1);
    end
endmodule
